// File: rtl/tx_burst_sequencer_pkg.sv
// Shared types and constants for the TX burst sequencer.
// The GUARD state exists only when TX_GUARD_EN is defined.
package tx_pkg;

    localparam int IQ_W = 12;
    localparam logic signed [IQ_W-1:0] PRE_AMP = 12'sd1024;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
`ifdef TX_GUARD_EN
        GUARD,
`endif
        DRAIN
    } tx_seq_state_t;

endpackage

// File: rtl/tx_burst_sequencer.sv
// TX burst sequencer: preamble, caller-sized payload, optional zero guard tail (TX_GUARD_EN),
// pushed through a single ready/valid output register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start, payload length latched on start
// PREAMBLE | emitting PREAMBLE_LEN samples alternating +/-PRE_AMP, q = 0
// PAYLOAD  | passing payload samples through, pl_ready follows load
// GUARD    | emitting GUARD_LEN zero samples (TX_GUARD_EN builds only)
// DRAIN    | waiting for the last sample to leave the output register
module tx_burst_sequencer
    import tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 16,
    parameter int GUARD_LEN    = 8,
    parameter int LEN_W        = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       payload_len,
    output logic                   busy,
    output logic                   done,
    input  logic                   pl_valid,
    output logic                   pl_ready,
    input  logic signed [IQ_W-1:0] pl_i,
    input  logic signed [IQ_W-1:0] pl_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IQ_W-1:0] out_i,
    output logic signed [IQ_W-1:0] out_q
);

    if (PREAMBLE_LEN < 1) begin : g_bad_preamble_len
        $error("tx_burst_sequencer: PREAMBLE_LEN must be at least 1");
    end
    if (GUARD_LEN < 1) begin : g_bad_guard_len
        $error("tx_burst_sequencer: GUARD_LEN must be at least 1");
    end

    localparam int PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

`ifdef TX_GUARD_EN
    localparam int GRD_W = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_LEN - 1);
    localparam tx_seq_state_t AFTER_PAYLOAD = GUARD;
`else
    localparam tx_seq_state_t AFTER_PAYLOAD = DRAIN;
`endif

    tx_seq_state_t          state, state_nxt;
    logic [LEN_W-1:0]       len_q, len_nxt;
    logic [LEN_W-1:0]       pay_cnt, pay_cnt_nxt, pay_cnt_inc;
    logic [PRE_W-1:0]       pre_cnt, pre_cnt_nxt;
`ifdef TX_GUARD_EN
    logic [GRD_W-1:0]       grd_cnt, grd_cnt_nxt;
`endif
    logic                   load;
    logic                   ld_valid;
    logic signed [IQ_W-1:0] ld_i, ld_q;

    // The output register accepts a new value whenever it is empty or being drained.
    assign load        = !out_valid || out_ready;
    assign busy        = (state != IDLE);
    assign pay_cnt_inc = pay_cnt + LEN_W'(1);

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        pay_cnt_nxt = pay_cnt;
        pre_cnt_nxt = pre_cnt;
`ifdef TX_GUARD_EN
        grd_cnt_nxt = grd_cnt;
`endif
        ld_valid    = 1'b0;
        ld_i        = '0;
        ld_q        = '0;
        pl_ready    = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = PREAMBLE;
                    len_nxt     = payload_len;
                    pay_cnt_nxt = '0;
                    pre_cnt_nxt = '0;
`ifdef TX_GUARD_EN
                    grd_cnt_nxt = '0;
`endif
                end
            end
            PREAMBLE: begin
                if (load) begin
                    ld_valid = 1'b1;
                    ld_i     = pre_cnt[0] ? -PRE_AMP : PRE_AMP;
                    if (pre_cnt == PRE_LAST) begin
                        state_nxt = (len_q == '0) ? AFTER_PAYLOAD : PAYLOAD;
                    end else begin
                        pre_cnt_nxt = pre_cnt + PRE_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                pl_ready = load;
                if (load) begin
                    // A load without pl_valid leaves a bubble in the output stream.
                    ld_valid = pl_valid;
                    ld_i     = pl_i;
                    ld_q     = pl_q;
                    if (pl_valid) begin
                        pay_cnt_nxt = pay_cnt_inc;
                        if (pay_cnt_inc == len_q) begin
                            state_nxt = AFTER_PAYLOAD;
                        end
                    end
                end
            end
`ifdef TX_GUARD_EN
            GUARD: begin
                if (load) begin
                    ld_valid = 1'b1;
                    if (grd_cnt == GRD_LAST) begin
                        state_nxt = DRAIN;
                    end else begin
                        grd_cnt_nxt = grd_cnt + GRD_W'(1);
                    end
                end
            end
`endif
            DRAIN: begin
                if (load) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            pay_cnt   <= '0;
            pre_cnt   <= '0;
`ifdef TX_GUARD_EN
            grd_cnt   <= '0;
`endif
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            pay_cnt <= pay_cnt_nxt;
            pre_cnt <= pre_cnt_nxt;
`ifdef TX_GUARD_EN
            grd_cnt <= grd_cnt_nxt;
`endif
            if (load) begin
                out_valid <= ld_valid;
                out_i     <= ld_i;
                out_q     <= ld_q;
            end
        end
    end

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Directed bench for tx_burst_sequencer; expected streams are built from the burst definition.
// Guard-tail expectations follow TX_GUARD_EN.
module tb_tx_burst_sequencer;

    localparam int PRE = 16;
`ifdef TX_GUARD_EN
    localparam int GRD = 8;
`else
    localparam int GRD = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [9:0]        payload_len = '0;
    logic              busy, done;
    logic              pl_valid = 1'b0;
    logic              pl_ready;
    logic signed [11:0] pl_i = '0, pl_q = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [11:0] out_i, out_q;

    int n_chk = 0;
    int n_bad = 0;

    tx_burst_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .payload_len (payload_len),
        .busy        (busy),
        .done        (done),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_i        (pl_i),
        .pl_q        (pl_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_i       (out_i),
        .out_q       (out_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One complete burst. Start is driven in the first cycle, which must be an idle cycle.
    task automatic burst(input int len, input bit toggle_rdy, input int starve_after,
                         input bit restart_in_payload);
        int  exp_i[$];
        int  exp_q[$];
        int  total;
        int  hs = 0, sent = 0, cyc = 0, first = -1, starve_cnt = 0, plr_bad = 0;
        bit  done_seen = 1'b0, prev_hold = 1'b0, starving;
        int  prev_i = 0, prev_q = 0;

        for (int k = 0; k < PRE; k++) begin
            exp_i.push_back((k % 2 == 0) ? 1024 : -1024);
            exp_q.push_back(0);
        end
        for (int k = 0; k < len; k++) begin
            exp_i.push_back(100 + k);
            exp_q.push_back(-(50 + k));
        end
        for (int k = 0; k < GRD; k++) begin
            exp_i.push_back(0);
            exp_q.push_back(0);
        end
        total = PRE + len + GRD;

        @(negedge clk);
        start       = 1'b1;
        payload_len = 10'(len);
        out_ready   = 1'b1;
        pl_valid    = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_plr", pl_ready, 0);

        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start     = restart_in_payload && (sent == 1);
            out_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
            starving  = (starve_after >= 0) && (sent == starve_after) && (starve_cnt < 5);
            if (starving) starve_cnt++;
            pl_valid  = !starving;
            pl_i      = 12'(100 + sent);
            pl_q      = 12'(-(50 + sent));
            #1;
            if (first < 0 && out_valid) begin
                first = cyc;
                chk("first_lat", cyc, 2);
            end
            if (prev_hold) begin
                chk("hold_v", out_valid, 1);
                chk("hold_i", out_i, prev_i);
                chk("hold_q", out_q, prev_q);
            end
            if (starving && starve_cnt >= 2) chk("bubble", out_valid, 0);
            if (pl_ready && (!busy || hs < PRE - 1 || sent >= len)) plr_bad++;
            if (out_valid && out_ready) begin
                if (hs < total) begin
                    chk("smp_i", out_i, exp_i[hs]);
                    chk("smp_q", out_q, exp_q[hs]);
                end else begin
                    chk("overrun", hs + 1, total);
                end
                hs++;
            end
            if (pl_valid && pl_ready) sent++;
            if (done) begin
                done_seen = 1'b1;
                chk("done_hs", hs, total);
                chk("done_with_hs", int'(out_valid && out_ready), 1);
                chk("sent", sent, len);
            end
            prev_hold = out_valid && !out_ready;
            prev_i    = out_i;
            prev_q    = out_q;
        end
        start = 1'b0;
        chk("timeout", done_seen, 1);
        chk("plr_outside", plr_bad, 0);
    endtask

    task automatic reset_mid();
        int dn = 0;
        @(negedge clk);
        start       = 1'b1;
        payload_len = 10'd4;
        out_ready   = 1'b1;
        pl_valid    = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            dn += int'(done);
        end
        chk("pre7_v", out_valid, 1);
        chk("pre7_i", out_i, -1024);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        dn += int'(done);
        chk("rst_v", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_no_done", dn, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_pl_ready", pl_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        burst(4, 1'b0, -1, 1'b0);   // basic
        burst(4, 1'b1, -1, 1'b0);   // back-pressure
        burst(6, 1'b0, 2, 1'b0);    // starvation
        burst(0, 1'b0, -1, 1'b0);   // zero length
        burst(5, 1'b0, -1, 1'b1);   // start while busy
        burst(3, 1'b0, -1, 1'b0);   // start on cycle after done
        reset_mid();
        burst(4, 1'b0, -1, 1'b0);   // fresh burst after reset

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_burst_sequencer.md
# tx_burst_sequencer

Sequences one transmit burst into the TX sample path: a fixed preamble, then a caller-sized payload taken from the modulator stream, then (optionally) a zero-valued guard tail. Sits between the symbol mapper and the 8-cycle sample-hold stage. Exposes a ready/valid stream on both sides and a start/busy/done control interface to the frame controller.

## Interface
- PREAMBLE_LEN, 16, number of preamble samples (≥1)
- GUARD_LEN, 8, number of guard samples (≥1; used only with TX_GUARD_EN)
- LEN_W, 10, width of payload length field
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  burst request, sampled only in IDLE
- payload_len  in  LEN_W  payload sample count, latched with start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- pl_valid  in  1  payload sample valid
- pl_ready  out  1  payload sample accepted
- pl_i, pl_q  in  12 each  signed payload I/Q
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream (hold stage) ready
- out_i, out_q  out  12 each  signed output I/Q

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GUARD, DRAIN.
- Single output register (out_valid/out_i/out_q). It loads when `load = !out_valid | out_ready`. It holds the value while out_valid & !out_ready.
- IDLE: on start, latch payload_len, clear counters, go to PREAMBLE, busy=1 from the next cycle. start in any other state is ignored.
- PREAMBLE: on each load, emit sample k: out_i = +PRE_AMP (k even) or −PRE_AMP (k odd), out_q = 0. After sample PREAMBLE_LEN−1 is loaded, go to PAYLOAD, or skip to GUARD/DRAIN if the latched length is 0.
- PAYLOAD: pl_ready = load. On pl_valid & pl_ready, copy pl_i/pl_q to the output and increment the payload count. A load cycle without pl_valid clears out_valid (bubble). After the latched length of samples is transferred, go to GUARD (or DRAIN). pl_ready is 0 in every other state.
- GUARD: on each load, emit out_i = out_q = 0 with out_valid = 1. After GUARD_LEN samples, go to DRAIN.
- DRAIN: wait for the last sample's output handshake (out_valid & out_ready). On that cycle pulse done=1, drop busy, return to IDLE. If the register is already empty, this happens immediately.
- Counters are LEN_W bits wide (preamble/guard counters sized by clog2 of their parameters). No wrap occurs: each phase ends at its terminal count.
- Reset values: out_valid=0, out_i=out_q=0, busy=0, done=0, pl_ready=0, state=IDLE.
- rst mid-burst abandons the burst immediately. The partially sent sample is dropped and no done pulse is produced.

## Timing
- Output latency: one cycle from a load condition to out_valid/out_i/out_q.
- Payload pass-through: a sample accepted in cycle n is on out_* in cycle n+1.
- With out_ready held at 1, sustains one sample per cycle with no inter-phase bubbles.
- Minimum burst: start at cycle 0, first preamble sample valid at cycle 2.
- done asserts in the same cycle as the handshake of the final sample. busy deasserts in the following cycle. A new start is accepted from that cycle on.
- Sample values are never altered once out_valid is asserted until the handshake.

## Configuration
- TX_GUARD_EN defined: the GUARD state exists and GUARD_LEN zero samples are appended after the payload.
- TX_GUARD_EN undefined: the GUARD state and its counter are removed, PAYLOAD (or PREAMBLE when length is 0) goes straight to DRAIN, and GUARD_LEN is ignored.

## Structure
- Shared package tx_pkg holds:
  - the state enum `tx_seq_state_t`
  - `PRE_AMP = 12'sd1024`
  - the I/Q sample width constant `IQ_W = 12`
- No sub-module. The output register and FSM are small enough to stay in one module.

## Test plan
- Basic burst: start, payload_len=4, out_ready=1, payload 100..103 always valid.
  - Expect 16 preamble samples alternating +1024/−1024 with q=0, then I=100..103, then 8 zero samples (with TX_GUARD_EN).
  - done at the 28th output handshake.
- Back-pressure: out_ready toggles 1/0 every cycle.
  - Each held sample is stable while out_ready=0.
  - Total of 28 handshakes, no loss or duplication.
- Payload starvation: pl_valid low for 5 cycles mid-payload.
  - out_valid drops for those cycles, then the payload resumes in order.
  - pl_ready stays 0 outside PAYLOAD.
- Zero-length payload: payload_len=0.
  - Preamble is followed directly by the guard (or by done without TX_GUARD_EN).
  - pl_ready is never asserted.
- Start while busy: a second start pulse during PAYLOAD is ignored. A start on the cycle after done is accepted and a second burst follows.
- Reset mid-preamble: rst at preamble sample 7.
  - Next cycle: out_valid=0, busy=0, no done pulse.
  - A fresh start produces a complete burst.
